// File: rtl/bob_runway_scheduler_pkg.sv
`default_nettype none
// ---- BobATC : message/reply encodings and message field helpers ---- Rev 1.0 ----
package BobATC;
  localparam int TYPE_W    = 3;
  localparam int MAX_MSG_W = 32;

  typedef enum logic [TYPE_W-1:0] {
    T_REQUEST   = 3'd0,
    T_DECLARE   = 3'd1,
    T_EMERGENCY = 3'd2
  } msg_type_t;

  typedef enum logic [TYPE_W-1:0] {
    R_HOLD          = 3'd0,
    R_DENY          = 3'd1,
    R_CLEAR_TAKEOFF = 3'd2,
    R_CLEAR_LAND    = 3'd3,
    R_ACK           = 3'd4,
    R_SAY_AGAIN     = 3'd5
  } reply_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_REPLY  = 2'd2,
    S_GRANT  = 2'd3
  } state_t;

  function automatic int rwy_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Layout is {id, type/reply, arg/runway}; callers zero-extend to MAX_MSG_W.
  function automatic logic [MAX_MSG_W-1:0] pack_msg(input logic [MAX_MSG_W-1:0] id,
                                                    input logic [TYPE_W-1:0]    code,
                                                    input logic [MAX_MSG_W-1:0] arg,
                                                    input int                   rwy_w);
    return (id << (rwy_w + TYPE_W)) | (MAX_MSG_W'(code) << rwy_w) | arg;
  endfunction

  function automatic logic [MAX_MSG_W-1:0] msg_id(input logic [MAX_MSG_W-1:0] m, input int rwy_w);
    return m >> (rwy_w + TYPE_W);
  endfunction

  function automatic logic [TYPE_W-1:0] msg_code(input logic [MAX_MSG_W-1:0] m, input int rwy_w);
    return TYPE_W'(m >> rwy_w);
  endfunction

  function automatic logic [MAX_MSG_W-1:0] msg_arg(input logic [MAX_MSG_W-1:0] m, input int rwy_w);
    return m & ((MAX_MSG_W'(1) << rwy_w) - MAX_MSG_W'(1));
  endfunction
endpackage
`default_nettype wire

// File: rtl/bob_runway_scheduler_fifo.sv
`default_nettype none
// ---- bob_sync_fifo : sync-reset FIFO, combinational read, count-based full/empty ---- Rev 1.0 ----
module bob_sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 15,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Explicit wrap keeps non-power-of-2 depths inside the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_rd) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_wr && !do_rd)      count_q <= count_q + CNT_W'(1);
      else if (do_rd && !do_wr) count_q <= count_q - CNT_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/bob_runway_scheduler.sv
`default_nettype none
// ---- bob_runway_scheduler : multi-runway ATC request decoder, queues and lock grants ---- Rev 1.0 ----
module bob_runway_scheduler
  import BobATC::*;
#(
  parameter  int NUM_RUNWAYS = 2,
  parameter  int ID_WIDTH    = 4,
  parameter  int TQ_DEPTH    = 15,
  parameter  int LQ_DEPTH    = 15,
  localparam int RWY_W       = rwy_width(NUM_RUNWAYS),
  localparam int MSG_W       = ID_WIDTH + TYPE_W + RWY_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [MSG_W-1:0]       req_msg,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_RUNWAYS-1:0] runway_blocked,
  output logic [MSG_W-1:0]       rep_msg,
  output logic                   rep_valid,
  input  logic                   rep_ready,
  output logic [NUM_RUNWAYS-1:0] runway_takeoff,
  output logic [NUM_RUNWAYS-1:0] runway_landing,
  output logic                   emergency,
  output logic                   tq_full,
  output logic                   lq_full
);
  localparam logic [RWY_W:0] RWY_LIMIT = (RWY_W + 1)'(NUM_RUNWAYS);

  state_t                               state_q, state_d;
  logic                                 alt_q, alt_d, emerg_q, emerg_d;
  logic [ID_WIDTH-1:0]                  emerg_owner_q, emerg_owner_d;
  logic [NUM_RUNWAYS-1:0]               lock_q, lock_d, land_q, land_d;
  logic [NUM_RUNWAYS-1:0][ID_WIDTH-1:0] owner_q, owner_d;
  logic [MSG_W-1:0]                     msg_q, msg_d, rep_q, rep_d;

  logic                   tq_push, tq_pop, tq_empty, lq_push, lq_pop, lq_empty;
  logic [ID_WIDTH-1:0]    tq_head, lq_head, dec_id, gnt_id;
  logic [TYPE_W-1:0]      dec_type;
  logic [RWY_W-1:0]       dec_arg, grant_rwy;
  logic [NUM_RUNWAYS-1:0] rwy_free;
  logic                   can_grant, take_grant;
  reply_t                 rep_code;

  bob_sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(TQ_DEPTH)) u_tq (
    .clock, .reset_n, .wr_en_i(tq_push), .wr_data_i(dec_id), .rd_en_i(tq_pop),
    .rd_data_o(tq_head), .full_o(tq_full), .empty_o(tq_empty));

  bob_sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(LQ_DEPTH)) u_lq (
    .clock, .reset_n, .wr_en_i(lq_push), .wr_data_i(dec_id), .rd_en_i(lq_pop),
    .rd_data_o(lq_head), .full_o(lq_full), .empty_o(lq_empty));

  assign dec_id   = ID_WIDTH'(msg_id(MAX_MSG_W'(msg_q), RWY_W));
  assign dec_type = msg_code(MAX_MSG_W'(msg_q), RWY_W);
  assign dec_arg  = RWY_W'(msg_arg(MAX_MSG_W'(msg_q), RWY_W));

  assign rwy_free = ~lock_q & ~runway_blocked;

  always_comb begin
    grant_rwy = '0;
    for (int r = NUM_RUNWAYS - 1; r >= 0; r--) begin
      if (rwy_free[r]) grant_rwy = RWY_W'(r);
    end
  end

  // alt_q alternates priority between a pending grant and a pending request.
  assign can_grant  = (|rwy_free) && !emerg_q && !(tq_empty && lq_empty);
  assign take_grant = (state_q == S_IDLE) && can_grant && (!req_valid || !alt_q);
  assign req_ready  = (state_q == S_IDLE) && !take_grant;
  assign rep_valid  = (state_q == S_REPLY) || (state_q == S_GRANT);
  assign rep_msg    = rep_q;

  assign runway_takeoff = lock_q & ~land_q;
  assign runway_landing = lock_q & land_q;
  assign emergency      = emerg_q;

  always_comb begin
    state_d = state_q;  alt_d = alt_q;  emerg_d = emerg_q;  emerg_owner_d = emerg_owner_q;
    lock_d  = lock_q;   land_d = land_q; owner_d = owner_q;  msg_d = msg_q;  rep_d = rep_q;
    tq_push = 1'b0;  tq_pop = 1'b0;  lq_push = 1'b0;  lq_pop = 1'b0;
    gnt_id   = tq_head;
    rep_code = R_SAY_AGAIN;
    case (state_q)
      S_IDLE: begin
        if (take_grant) begin
          if (!lq_empty) begin lq_pop = 1'b1; gnt_id = lq_head; end
          else           begin tq_pop = 1'b1; gnt_id = tq_head; end
          lock_d[grant_rwy]  = 1'b1;
          land_d[grant_rwy]  = !lq_empty;
          owner_d[grant_rwy] = gnt_id;
          rep_code = lq_empty ? R_CLEAR_TAKEOFF : R_CLEAR_LAND;
          rep_d    = MSG_W'(pack_msg(MAX_MSG_W'(gnt_id), rep_code, MAX_MSG_W'(grant_rwy), RWY_W));
          alt_d    = !alt_q;
          state_d  = S_GRANT;
        end else if (req_valid) begin
          msg_d   = req_msg;
          alt_d   = !alt_q;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (dec_type)
          T_REQUEST: begin
            if (dec_arg[0]) begin
              if (lq_full) rep_code = R_DENY;
              else begin lq_push = 1'b1; rep_code = R_HOLD; end
            end else begin
              if (tq_full) rep_code = R_DENY;
              else begin tq_push = 1'b1; rep_code = R_HOLD; end
            end
          end
          T_DECLARE: begin
            if (({1'b0, dec_arg} < RWY_LIMIT) && lock_q[dec_arg] && (owner_q[dec_arg] == dec_id)) begin
              lock_d[dec_arg] = 1'b0;
              rep_code = R_ACK;
            end else if (emerg_q && (emerg_owner_q == dec_id)) begin
              emerg_d  = 1'b0;
              rep_code = R_ACK;
            end
          end
          T_EMERGENCY: begin
            if (emerg_q) rep_code = R_DENY;
            else begin emerg_d = 1'b1; emerg_owner_d = dec_id; rep_code = R_ACK; end
          end
          default: ;
        endcase
        // Non-grant replies echo the request's argument in the runway field.
        rep_d   = MSG_W'(pack_msg(MAX_MSG_W'(dec_id), rep_code, MAX_MSG_W'(dec_arg), RWY_W));
        state_d = S_REPLY;
      end
      S_REPLY, S_GRANT: begin
        if (rep_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  alt_q <= 1'b0;  emerg_q <= 1'b0;  emerg_owner_q <= '0;
      lock_q  <= '0;      land_q <= '0;   owner_q <= '0;    msg_q <= '0;  rep_q <= '0;
    end else begin
      state_q <= state_d;  alt_q <= alt_d;  emerg_q <= emerg_d;  emerg_owner_q <= emerg_owner_d;
      lock_q  <= lock_d;   land_q <= land_d; owner_q <= owner_d;  msg_q <= msg_d;  rep_q <= rep_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bob_runway_scheduler.sv
`default_nettype none
// ---- tb_bob_runway_scheduler : directed + random traffic against a transaction-level ATC model ---- Rev 1.0 ----
module tb_bob_runway_scheduler;
  localparam int N     = 2;
  localparam int IDW   = 4;
  localparam int TQ_D  = 15;
  localparam int LQ_D  = 15;
  localparam int MSG_W = 8;
  localparam int K_NONE = 0, K_ACCEPT = 1, K_GRANT = 2;
  localparam int R_HOLD = 0, R_DENY = 1, R_CLR_TO = 2, R_CLR_LD = 3, R_ACK = 4, R_SAY = 5;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [MSG_W-1:0] req_msg;
  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     runway_blocked;
  logic [MSG_W-1:0] rep_msg;
  logic             rep_valid;
  logic             rep_ready;
  logic [N-1:0]     runway_takeoff, runway_landing;
  logic             emergency, tq_full, lq_full;

  always #5 clock = ~clock;

  bob_runway_scheduler #(.NUM_RUNWAYS(N), .ID_WIDTH(IDW), .TQ_DEPTH(TQ_D), .LQ_DEPTH(LQ_D)) dut (
    .clock(clock), .reset_n(reset_n), .req_msg(req_msg), .req_valid(req_valid),
    .req_ready(req_ready), .runway_blocked(runway_blocked), .rep_msg(rep_msg),
    .rep_valid(rep_valid), .rep_ready(rep_ready), .runway_takeoff(runway_takeoff),
    .runway_landing(runway_landing), .emergency(emergency), .tq_full(tq_full), .lq_full(lq_full));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queues of IDs, per-runway lock/mode/owner, emergency, alternation flag.
  int       tq[$];
  int       lq[$];
  bit [N-1:0] lk, ld;
  int       own[N];
  bit       em;
  int       emo;
  bit       alt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input int id, input int typ, input int arg);
    return {IDW'(id), 3'(typ), 1'(arg)};
  endfunction

  task automatic model_reset();
    tq.delete(); lq.delete();
    lk = '0; ld = '0; em = 1'b0; emo = 0; alt = 1'b0;
    for (int r = 0; r < N; r++) own[r] = 0;
  endtask

  task automatic predict(input bit present, input logic [MSG_W-1:0] m,
                         output int kind, output logic [MSG_W-1:0] exp);
    int  fr, id, typ, arg, code;
    bit  elig, land;
    fr = -1;
    for (int r = N - 1; r >= 0; r--) if (!lk[r] && !runway_blocked[r]) fr = r;
    elig = (fr >= 0) && !em && (tq.size() > 0 || lq.size() > 0);
    if (elig && (!present || !alt)) begin
      land = (lq.size() > 0);
      if (land) id = lq.pop_front();
      else      id = tq.pop_front();
      lk[fr] = 1'b1; ld[fr] = land; own[fr] = id;
      alt  = !alt;
      kind = K_GRANT;
      exp  = {IDW'(id), 3'(land ? R_CLR_LD : R_CLR_TO), 1'(fr)};
    end else if (present) begin
      id = int'(m[7:4]); typ = int'(m[3:1]); arg = int'(m[0]);
      code = R_SAY;
      case (typ)
        0: begin
          if (arg == 1) begin
            if (lq.size() == LQ_D) code = R_DENY; else begin lq.push_back(id); code = R_HOLD; end
          end else begin
            if (tq.size() == TQ_D) code = R_DENY; else begin tq.push_back(id); code = R_HOLD; end
          end
        end
        1: begin
          if (arg < N && lk[arg] && own[arg] == id) begin lk[arg] = 1'b0; code = R_ACK; end
          else if (em && emo == id) begin em = 1'b0; code = R_ACK; end
        end
        2: begin
          if (em) code = R_DENY; else begin em = 1'b1; emo = id; code = R_ACK; end
        end
        default: code = R_SAY;
      endcase
      alt  = !alt;
      kind = K_ACCEPT;
      exp  = {m[7:4], 3'(code), m[0]};
    end else begin
      kind = K_NONE;
      exp  = '0;
    end
  endtask

  task automatic check_status();
    check_val("rwy_takeoff", runway_takeoff, lk & ~ld);
    check_val("rwy_landing", runway_landing, lk & ld);
    check_val("emergency", emergency, em);
    check_val("tq_full", tq_full, tq.size() == TQ_D);
    check_val("lq_full", lq_full, lq.size() == LQ_D);
  endtask

  // One IDLE decision plus its reply handshake. Entered and left at a negedge with the DUT idle.
  task automatic slot(input bit present, input logic [MSG_W-1:0] m, input int stall, output bit accepted);
    int               kind;
    logic [MSG_W-1:0] exp;
    req_valid = present; req_msg = m; rep_ready = 1'b0;
    #1;
    predict(present, m, kind, exp);
    check_val("req_ready_idle", req_ready, kind != K_GRANT);
    @(posedge clock); @(negedge clock);
    accepted = (kind == K_ACCEPT);
    if (accepted) req_valid = 1'b0;
    if (kind == K_NONE) begin
      check_val("idle_rep_valid", rep_valid, 0);
      return;
    end
    if (kind == K_ACCEPT) begin
      check_val("decode_rep_valid", rep_valid, 0);
      @(negedge clock);
    end
    check_val("rep_valid", rep_valid, 1);
    check_val("rep_msg", rep_msg, exp);
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check_val("stall_rep_valid", rep_valid, 1);
      check_val("stall_rep_msg", rep_msg, exp);
      check_val("stall_req_ready", req_ready, 0);
    end
    rep_ready = 1'b1;
    @(negedge clock);
    rep_ready = 1'b0;
    check_val("post_rep_valid", rep_valid, 0);
    check_status();
  endtask

  task automatic send(input logic [MSG_W-1:0] m, input int stall);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) slot(1'b1, m, stall, acc);
    check_val("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) slot(1'b0, '0, 0, acc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req_valid = 1'b0; rep_ready = 1'b0; runway_blocked = '0;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_state();
    check_val("rst_rep_valid", rep_valid, 0);
    check_val("rst_rep_msg", rep_msg, 0);
    check_val("rst_req_ready", req_ready, 1);
    check_status();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit               acc, pend, pres;
    logic [MSG_W-1:0] pm;
    int               t, typ, id, arg;
    req_valid = 1'b0; req_msg = '0; rep_ready = 1'b0; runway_blocked = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check_reset_state();

    // Single takeoff: hold, then clearance on runway 0.
    send(mk(3, 0, 0), 0);
    idle(1);
    check_val("t1_takeoff_lock", runway_takeoff, 2'b01);

    // Landings take priority over a queued takeoff.
    do_reset();
    send(mk(1, 0, 1), 0); send(mk(2, 0, 1), 0); send(mk(7, 0, 0), 0);
    idle(3);
    check_val("t2_landing_locks", runway_landing, 2'b11);
    check_val("t2_takeoff_locks", runway_takeoff, 2'b00);

    // Fill the takeoff queue with both runways closed.
    do_reset();
    runway_blocked = 2'b11;
    for (int i = 0; i < 16; i++) send(mk(i, 0, 0), 0);
    check_val("t3_tq_full", tq_full, 1);

    // Runway release only by its owner.
    do_reset();
    send(mk(2, 0, 0), 0); send(mk(9, 0, 0), 0);
    idle(3);
    check_val("t4_locks_before", runway_takeoff, 2'b11);
    send(mk(4, 1, 1), 0);
    check_val("t4_wrong_owner", runway_takeoff, 2'b11);
    send(mk(9, 1, 1), 0);
    check_val("t4_released", runway_takeoff, 2'b01);

    // Emergency freezes grants until its owner declares.
    do_reset();
    send(mk(5, 2, 0), 0);
    check_val("t5_emergency_set", emergency, 1);
    send(mk(6, 0, 0), 0);
    idle(3);
    check_val("t5_frozen", runway_takeoff, 2'b00);
    send(mk(5, 1, 0), 0);
    idle(1);
    check_val("t5_resumed", runway_takeoff, 2'b01);
    check_val("t5_emergency_clr", emergency, 0);

    // Long back-pressure, then reset while a reply is pending.
    do_reset();
    send(mk(1, 0, 0), 10);
    do_reset();
    req_valid = 1'b1; req_msg = mk(2, 0, 1);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check_val("t6_reply_pending", rep_valid, 1);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    check_reset_state();

    // Randomized traffic.
    pend = 1'b0; pm = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 4) != 0) begin
        t   = $urandom_range(0, 19);
        typ = (t < 10) ? 0 : (t < 15) ? 1 : (t < 17) ? 2 : $urandom_range(3, 7);
        id  = $urandom_range(0, 15);
        arg = $urandom_range(0, 1);
        if (typ == 1 && $urandom_range(0, 1) == 1) id = (em && $urandom_range(0, 1) == 1) ? emo : own[arg];
        pm   = mk(id, typ, arg);
        pend = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) runway_blocked = 2'($urandom);
      pres = pend && ($urandom_range(0, 3) != 0);
      slot(pres, pm, $urandom_range(0, 3), acc);
      if (acc) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
